// File: rtl/ksm_timing.sv
// KSM raster timing generator: col/row counters, delayed sync/blank,
// line/frame strobes, frame counter with blink and retrace interrupt.
module ksm_timing #(
    parameter int unsigned H_TOTAL      = 1056,
    parameter int unsigned H_VIS_START  = 40,
    parameter int unsigned H_VIS_END    = 839,
    parameter int unsigned H_SYNC_START = 928,
    parameter int unsigned V_TOTAL      = 628,
    parameter int unsigned V_VIS_START  = 23,
    parameter int unsigned V_VIS_END    = 622,
    parameter int unsigned V_SYNC_START = 624,
    parameter bit          SYNC_POL     = 1'b1,
    parameter int unsigned PIPE_DLY     = 1,
    parameter int unsigned BLINK_BIT    = 4
) (
    input  logic        clk50,
    input  logic        vreset,
    output logic [10:0] col,
    output logic [9:0]  row,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        line_end,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        blink,
    input  logic        irq_en,
    input  logic        irq_ack,
    output logic        irq
);

    // Delay-line word layout: {hs, vs, hb, vb}; idle value = no sync, blanked.
    localparam logic [3:0] PIPE_IDLE = 4'b0011;

    logic       col_last;
    logic       row_last;
    logic       hs_raw;
    logic       vs_raw;
    logic       hb_raw;
    logic       vb_raw;
    logic       set_evt;
    logic       pending;
    logic       hs_d;
    logic       vs_d;
    logic [3:0] pipe [PIPE_DLY];

    assign col_last = (col == 11'(H_TOTAL - 1));
    assign row_last = (row == 10'(V_TOTAL - 1));

    assign hs_raw = (col >= 11'(H_SYNC_START));
    assign vs_raw = (row >= 10'(V_SYNC_START));
    assign hb_raw = (col < 11'(H_VIS_START)) | (col > 11'(H_VIS_END));
    assign vb_raw = (row < 10'(V_VIS_START)) | (row > 10'(V_VIS_END));

    assign set_evt = (col == 11'd0) && (row == 10'(V_VIS_END + 1));

    always_ff @(posedge clk50 or posedge vreset) begin
        if (vreset) begin
            col       <= '0;
            row       <= '0;
            frame_cnt <= '0;
        end else if (col_last) begin
            col <= '0;
            if (row_last) begin
                row       <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                row <= row + 10'd1;
            end
        end else begin
            col <= col + 11'd1;
        end
    end

    always_ff @(posedge clk50 or posedge vreset) begin
        if (vreset) begin
            for (int i = 0; i < int'(PIPE_DLY); i++) pipe[i] <= PIPE_IDLE;
        end else begin
            pipe[0] <= {hs_raw, vs_raw, hb_raw, vb_raw};
            for (int i = 1; i < int'(PIPE_DLY); i++) pipe[i] <= pipe[i-1];
        end
    end

    // A set event in the same cycle as an ack must leave the request pending.
    always_ff @(posedge clk50 or posedge vreset) begin
        if (vreset) begin
            pending <= 1'b0;
        end else if (set_evt) begin
            pending <= 1'b1;
        end else if (irq_ack) begin
            pending <= 1'b0;
        end
    end

    assign {hs_d, vs_d, hblank, vblank} = pipe[PIPE_DLY-1];

    assign hsync       = ~(hs_d ^ SYNC_POL);
    assign vsync       = ~(vs_d ^ SYNC_POL);
    assign line_end    = col_last;
    assign frame_start = col_last & row_last;
    assign blink       = frame_cnt[BLINK_BIT];
    assign irq         = pending & irq_en;

endmodule

// File: tb/tb_ksm_timing.sv
// Scoreboard bench for ksm_timing: full-size instance A, shrunk instance B.
module tb_ksm_timing;

    localparam int B0 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a, rst_b;
    logic        en_a, ack_a, en_b, ack_b;
    logic [10:0] col_a, col_b;
    logic [9:0]  row_a, row_b;
    logic        hs_a, vs_a, hb_a, vb_a, le_a, fs_a, bl_a, irq_a;
    logic        hs_b, vs_b, hb_b, vb_b, le_b, fs_b, bl_b, irq_b;
    logic [7:0]  fc_a, fc_b;

    ksm_timing dut_a (
        .clk50(clk), .vreset(rst_a), .col(col_a), .row(row_a),
        .hsync(hs_a), .vsync(vs_a), .hblank(hb_a), .vblank(vb_a),
        .line_end(le_a), .frame_start(fs_a), .frame_cnt(fc_a),
        .blink(bl_a), .irq_en(en_a), .irq_ack(ack_a), .irq(irq_a)
    );

    ksm_timing #(
        .H_TOTAL(40), .H_VIS_START(4), .H_VIS_END(31), .H_SYNC_START(34),
        .V_TOTAL(20), .V_VIS_START(2), .V_VIS_END(15), .V_SYNC_START(17),
        .SYNC_POL(1'b0), .PIPE_DLY(2), .BLINK_BIT(4)
    ) dut_b (
        .clk50(clk), .vreset(rst_b), .col(col_b), .row(row_b),
        .hsync(hs_b), .vsync(vs_b), .hblank(hb_b), .vblank(vb_b),
        .line_end(le_b), .frame_start(fs_b), .frame_cnt(fc_b),
        .blink(bl_b), .irq_en(en_b), .irq_ack(ack_b), .irq(irq_b)
    );

    typedef enum {
        COL_A, ROW_A, HS_A, VS_A, HB_A, VB_A, LE_A, FS_A, FC_A, IRQ_A,
        COL_B, ROW_B, HS_B, VS_B, HB_B, VB_B, LE_B, FS_B, FC_B, BL_B,
        IRQ_B
    } sig_e;

    typedef struct {
        int    k;
        sig_e  s;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic expect_at(input int k, input sig_e s, input int exp,
                             input string name);
        chk_t c;
        c.k = k; c.s = s; c.exp = exp; c.name = name;
        sb.push_back(c);
    endtask

    function automatic int sample(input sig_e s);
        case (s)
            COL_A: return int'(col_a);
            ROW_A: return int'(row_a);
            HS_A:  return int'(hs_a);
            VS_A:  return int'(vs_a);
            HB_A:  return int'(hb_a);
            VB_A:  return int'(vb_a);
            LE_A:  return int'(le_a);
            FS_A:  return int'(fs_a);
            FC_A:  return int'(fc_a);
            IRQ_A: return int'(irq_a);
            COL_B: return int'(col_b);
            ROW_B: return int'(row_b);
            HS_B:  return int'(hs_b);
            VS_B:  return int'(vs_b);
            HB_B:  return int'(hb_b);
            VB_B:  return int'(vb_b);
            LE_B:  return int'(le_b);
            FS_B:  return int'(fs_b);
            FC_B:  return int'(fc_b);
            BL_B:  return int'(bl_b);
            IRQ_B: return int'(irq_b);
            default: return -1;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (B0 + sb[i].k == cyc) begin
                int act;
                act = sample(sb[i].s);
                n_chk++;
                if (act != sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s k=%0d: got %0d expected %0d",
                             sb[i].name, sb[i].k, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic at_k(input int k);
        while (cyc < B0 + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        en_a  = 1'b0; ack_a = 1'b0;
        en_b  = 1'b1; ack_b = 1'b0;

        expect_at(-2, COL_A, 0, "rst_col_a");
        expect_at(-2, HS_A, 0, "rst_hs_a");
        expect_at(-2, HB_A, 1, "rst_hb_a");
        expect_at(-2, VB_A, 1, "rst_vb_a");
        expect_at(-2, LE_A, 0, "rst_le_a");
        expect_at(-2, HS_B, 1, "rst_hs_b");
        expect_at(-2, VS_B, 1, "rst_vs_b");
        expect_at(-2, FC_B, 0, "rst_fc_b");
        expect_at(-2, IRQ_B, 0, "rst_irq_b");

        expect_at(0, COL_A, 0, "a_col_first");
        expect_at(0, ROW_A, 0, "a_row_first");
        expect_at(0, HB_A, 1, "a_hb_first");
        expect_at(40, HB_A, 1, "a_hb_40");
        expect_at(41, HB_A, 0, "a_hb_41");
        expect_at(840, HB_A, 0, "a_hb_840");
        expect_at(841, HB_A, 1, "a_hb_841");
        expect_at(1054, LE_A, 0, "a_le_1054");
        expect_at(1055, COL_A, 1055, "a_col_1055");
        expect_at(1055, LE_A, 1, "a_le_1055");
        expect_at(1055, ROW_A, 0, "a_row_1055");
        expect_at(1055, FS_A, 0, "a_fs_1055");
        expect_at(1056, COL_A, 0, "a_col_wrap");
        expect_at(1056, ROW_A, 1, "a_row_wrap");
        expect_at(1056, LE_A, 0, "a_le_wrap");
        expect_at(6208, COL_A, 928, "a_col_6208");
        expect_at(6208, HS_A, 0, "a_hs_928");
        expect_at(6209, HS_A, 1, "a_hs_929");
        expect_at(6336, HS_A, 1, "a_hs_r6c0");
        expect_at(6336, ROW_A, 6, "a_row_6");
        expect_at(6337, HS_A, 0, "a_hs_r6c1");
        expect_at(6337, VS_A, 0, "a_vs_r6");
        expect_at(6337, IRQ_A, 0, "a_irq_masked");
        expect_at(24288, ROW_A, 23, "a_row_23");
        expect_at(24288, VB_A, 1, "a_vb_r23c0");
        expect_at(24289, VB_A, 0, "a_vb_r23c1");
        expect_at(24289, FC_A, 0, "a_fc");

        expect_at(5, HB_B, 1, "b_hb_5");
        expect_at(6, HB_B, 0, "b_hb_6");
        expect_at(681, VS_B, 1, "b_vs_681");
        expect_at(682, VS_B, 0, "b_vs_682");
        expect_at(801, VS_B, 0, "b_vs_801");
        expect_at(802, VS_B, 1, "b_vs_802");
        expect_at(798, FS_B, 0, "b_fs_798");
        expect_at(798, LE_B, 0, "b_le_798");
        expect_at(799, FS_B, 1, "b_fs_799");
        expect_at(799, LE_B, 1, "b_le_799");
        expect_at(799, FC_B, 0, "b_fc_799");
        expect_at(800, FC_B, 1, "b_fc_800");
        expect_at(800, COL_B, 0, "b_col_800");
        expect_at(800, ROW_B, 0, "b_row_800");
        expect_at(640, IRQ_B, 0, "b_irq_set_cyc");
        expect_at(641, IRQ_B, 1, "b_irq_raised");
        expect_at(645, IRQ_B, 1, "b_irq_ack_cyc");
        expect_at(646, IRQ_B, 0, "b_irq_acked");

        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (col_a != 11'd0) begin
            n_fail++;
            $display("FAIL inl_rst_col_a: got %0d", col_a);
        end
        n_chk++;
        if (row_a != 10'd0) begin
            n_fail++;
            $display("FAIL inl_rst_row_a: got %0d", row_a);
        end
        n_chk++;
        if (vs_a !== 1'b0) begin
            n_fail++;
            $display("FAIL inl_rst_vs_a: got %0b", vs_a);
        end
        n_chk++;
        if (fc_a != 8'd0) begin
            n_fail++;
            $display("FAIL inl_rst_fc_a: got %0d", fc_a);
        end
        n_chk++;
        if (vb_b !== 1'b1) begin
            n_fail++;
            $display("FAIL inl_rst_vb_b: got %0b", vb_b);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;

        at_k(645);  ack_b = 1'b1;
        at_k(646);  ack_b = 1'b0;

        expect_at(1441, IRQ_B, 1, "b_irq_set_wins");
        expect_at(1446, IRQ_B, 0, "b_irq_acked2");
        at_k(1440); ack_b = 1'b1;
        at_k(1441); ack_b = 1'b0;
        at_k(1445); ack_b = 1'b1;
        at_k(1446); ack_b = 1'b0;

        expect_at(2241, IRQ_B, 0, "b_irq_masked");
        expect_at(2250, IRQ_B, 1, "b_irq_unmask");
        expect_at(2256, IRQ_B, 0, "b_irq_acked3");
        at_k(1700); en_b = 1'b0;
        at_k(2250); en_b = 1'b1;
        at_k(2255); ack_b = 1'b1;
        at_k(2256); ack_b = 1'b0;

        expect_at(3040, IRQ_B, 0, "b_irq_held_pre");
        expect_at(3041, IRQ_B, 1, "b_irq_held_set");
        expect_at(3042, IRQ_B, 0, "b_irq_held_clr");
        expect_at(3200, FC_B, 4, "b_fc_4");
        at_k(2900); ack_b = 1'b1;
        at_k(3100); ack_b = 1'b0;

        expect_at(3604, ROW_B, 10, "b_row_prerst");
        expect_at(3604, COL_B, 4, "b_col_prerst");
        expect_at(3605, COL_B, 0, "b_rst_col");
        expect_at(3605, ROW_B, 0, "b_rst_row");
        expect_at(3605, HS_B, 1, "b_rst_hs");
        expect_at(3605, VS_B, 1, "b_rst_vs");
        expect_at(3605, HB_B, 1, "b_rst_hb");
        expect_at(3605, VB_B, 1, "b_rst_vb");
        expect_at(3605, FC_B, 0, "b_rst_fc");
        expect_at(3605, LE_B, 0, "b_rst_le");
        expect_at(3606, IRQ_B, 0, "b_rst_irq");
        expect_at(3608, COL_B, 0, "b_resume_col");
        expect_at(3650, COL_B, 2, "b_resume_col42");
        expect_at(3650, ROW_B, 1, "b_resume_row42");
        expect_at(3608 + 12799, FC_B, 15, "b_fc_15");
        expect_at(3608 + 12799, BL_B, 0, "b_blink_15");
        expect_at(3608 + 12800, FC_B, 16, "b_fc_16");
        expect_at(3608 + 12800, BL_B, 1, "b_blink_16");
        at_k(3605); rst_b = 1'b1;
        #1;
        n_chk++;
        if (col_b != 11'd0) begin
            n_fail++;
            $display("FAIL inl_async_col_b: got %0d", col_b);
        end
        n_chk++;
        if (row_b != 10'd0) begin
            n_fail++;
            $display("FAIL inl_async_row_b: got %0d", row_b);
        end
        n_chk++;
        if (hs_b !== 1'b1) begin
            n_fail++;
            $display("FAIL inl_async_hs_b: got %0b", hs_b);
        end
        at_k(3608); rst_b = 1'b0;

        at_k(24295);
        foreach (sb[i]) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s k=%0d: never sampled, expected %0d",
                     sb[i].name, sb[i].k, sb[i].exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
